// File: rtl/huff_pkg.sv
// Shared types and constants for the three-symbol Huffman encoder.
//   MAX_CHAR_COUNT : symbols per run
//   FREQ_W / SUM_W : input frequency width / internal node frequency width
//   CODE_W         : code value and mask width
//   NODE_CNT       : leaves plus internal nodes (2N-1)
//   state_t        : top-level run sequencing
//   node_t         : one entry of the tree node array
package huff_pkg;

   localparam int MAX_CHAR_COUNT = 3;
   localparam int FREQ_W         = 3;
   localparam int CODE_W         = MAX_CHAR_COUNT;
   localparam int NODE_CNT       = 2 * MAX_CHAR_COUNT - 1;
   localparam int SUM_W          = FREQ_W + 2;
   localparam int IDX_W          = 3;
   localparam int CNT_W          = 2;
   localparam int OCNT_W         = 3;
   // ranking key = {freq, is_leaf, index}; smaller key ranks first
   localparam int KEY_W          = SUM_W + 1 + IDX_W;

   typedef enum logic [2:0] {
      LOAD,
      BUILD,
      ENCODE,
      OUTPUT,
      DONE
   } state_t;

   typedef struct packed {
      logic [SUM_W-1:0] freq;
      logic             is_leaf;
      logic             active;
      logic [IDX_W-1:0] child0;
      logic [IDX_W-1:0] child1;
   } node_t;

   // Internal nodes get is_leaf=0 so they win frequency ties against leaves;
   // the index then orders leaves by input position and internal nodes by age.
   function automatic logic [KEY_W-1:0] rank_key(input logic [SUM_W-1:0] freq,
                                                 input logic             is_leaf,
                                                 input logic [IDX_W-1:0] idx);
      return {freq, is_leaf, idx};
   endfunction

endpackage

// File: rtl/huffman_encoder_min2.sv
// Combinational selection of the two lowest-ranked active nodes.
//   node_freq / node_leaf / node_act : per-node fields of the node array
//   min0_idx : smallest active node (becomes child-0)
//   min1_idx : second smallest active node (becomes child-1)
import huff_pkg::*;

module huff_min2 (
   input  logic [NODE_CNT-1:0][SUM_W-1:0] node_freq,
   input  logic [NODE_CNT-1:0]            node_leaf,
   input  logic [NODE_CNT-1:0]            node_act,
   output logic [IDX_W-1:0]               min0_idx,
   output logic [IDX_W-1:0]               min1_idx
);

   logic [KEY_W-1:0] k0, k1, key;

   // Keys are unique (index is part of the key) and never all-ones, so
   // starting from all-ones guarantees the first active nodes replace them.
   always_comb begin
      k0       = '1;
      k1       = '1;
      key      = '0;
      min0_idx = '0;
      min1_idx = '0;
      for (int i = 0; i < NODE_CNT; i++) begin
         key = rank_key(node_freq[i], node_leaf[i], IDX_W'(i));
         if (node_act[i]) begin
            if (key < k0) begin
               k1       = k0;
               min1_idx = min0_idx;
               k0       = key;
               min0_idx = IDX_W'(i);
            end else if (key < k1) begin
               k1       = key;
               min1_idx = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/huffman_encoder.sv
// Three-symbol Huffman encoder behind a 12-bit pin-limited interface.
//   clk    : rising-edge clock
//   reset  : synchronous, active-low; aborts any run and returns to LOAD
//   io_in  : [11] load valid, [10:8] frequency, [7:0] ASCII character
//   io_out : [11:9] zero, [8] output valid, [7:0] payload
// Flow: LOAD (3 symbols) -> BUILD (2 merges) -> ENCODE (1 cycle)
//       -> OUTPUT (char word + {mask,value} word per leaf) -> DONE.
import huff_pkg::*;

module huffman_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] io_in,
   output logic [11:0] io_out
);

   state_t                                 state_q, state_d;
   logic [CNT_W-1:0]                       load_cnt_q, load_cnt_d;
   node_t [NODE_CNT-1:0]                   nodes_q, nodes_d;
   logic [MAX_CHAR_COUNT-1:0][4:0]         chars_q, chars_d;
   logic [IDX_W-1:0]                       new_idx_q, new_idx_d;
   logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0]  code_q, code_d;
   logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0]  mask_q, mask_d;
   logic [OCNT_W-1:0]                      out_cnt_q, out_cnt_d;
   logic [11:0]                            io_out_q, io_out_d;

   logic [NODE_CNT-1:0][SUM_W-1:0]         node_freq;
   logic [NODE_CNT-1:0]                    node_leaf;
   logic [NODE_CNT-1:0]                    node_act;
   logic [IDX_W-1:0]                       min0_idx, min1_idx;

   node_t                                  nd;
   logic [IDX_W-1:0]                       cur;
   logic [CODE_W-1:0]                      val, msk;
   logic                                   found;
   logic [1:0]                             leaf;

   // upper character bits are rebuilt as 3'b011 on output
   logic unused_char_hi;
   assign unused_char_hi = ^io_in[7:5];

   always_comb begin
      for (int i = 0; i < NODE_CNT; i++) begin
         node_freq[i] = nodes_q[i].freq;
         node_leaf[i] = nodes_q[i].is_leaf;
         node_act[i]  = nodes_q[i].active;
      end
   end

   huff_min2 u_min2 (
      .node_freq (node_freq),
      .node_leaf (node_leaf),
      .node_act  (node_act),
      .min0_idx  (min0_idx),
      .min1_idx  (min1_idx)
   );

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      nodes_d    = nodes_q;
      chars_d    = chars_q;
      new_idx_d  = new_idx_q;
      code_d     = code_q;
      mask_d     = mask_q;
      out_cnt_d  = out_cnt_q;
      io_out_d   = '0;
      nd         = '0;
      cur        = '0;
      val        = '0;
      msk        = '0;
      found      = 1'b0;
      leaf       = out_cnt_q[2:1];

      case (state_q)
         LOAD: begin
            if (io_in[11]) begin
               nodes_d[load_cnt_q].freq    = SUM_W'(io_in[10:8]);
               nodes_d[load_cnt_q].is_leaf = 1'b1;
               nodes_d[load_cnt_q].active  = 1'b1;
               nodes_d[load_cnt_q].child0  = '0;
               nodes_d[load_cnt_q].child1  = '0;
               chars_d[load_cnt_q]         = io_in[4:0];
               if (load_cnt_q == CNT_W'(MAX_CHAR_COUNT - 1)) begin
                  load_cnt_d = '0;
                  state_d    = BUILD;
               end else begin
                  load_cnt_d = load_cnt_q + 1'b1;
               end
            end
         end

         BUILD: begin
            nd.freq    = nodes_q[min0_idx].freq + nodes_q[min1_idx].freq;
            nd.is_leaf = 1'b0;
            nd.active  = 1'b1;
            nd.child0  = min0_idx;
            nd.child1  = min1_idx;
            nodes_d[min0_idx].active = 1'b0;
            nodes_d[min1_idx].active = 1'b0;
            nodes_d[new_idx_q]       = nd;
            new_idx_d = new_idx_q + 1'b1;
            if (new_idx_q == IDX_W'(NODE_CNT - 1)) state_d = ENCODE;
         end

         // Root is the last node built. With three symbols every internal
         // node has at most one internal child, so when the leaf is not a
         // direct child the walk descends into the internal one.
         ENCODE: begin
            for (int l = 0; l < MAX_CHAR_COUNT; l++) begin
               cur   = IDX_W'(NODE_CNT - 1);
               val   = '0;
               msk   = '0;
               found = 1'b0;
               for (int d = 0; d < CODE_W; d++) begin
                  if (!found) begin
                     val = {val[CODE_W-2:0], 1'b0};
                     msk = {msk[CODE_W-2:0], 1'b1};
                     if (nodes_q[cur].child0 == IDX_W'(l)) begin
                        found = 1'b1;
                     end else if (nodes_q[cur].child1 == IDX_W'(l)) begin
                        val[0] = 1'b1;
                        found  = 1'b1;
                     end else if (!nodes_q[nodes_q[cur].child0].is_leaf) begin
                        cur = nodes_q[cur].child0;
                     end else begin
                        val[0] = 1'b1;
                        cur    = nodes_q[cur].child1;
                     end
                  end
               end
               code_d[l] = val;
               mask_d[l] = msk;
            end
            out_cnt_d = '0;
            state_d   = OUTPUT;
         end

         OUTPUT: begin
            if (!out_cnt_q[0])
               io_out_d = {3'b000, 1'b1, 3'b011, chars_q[leaf]};
            else
               io_out_d = {3'b000, 1'b1, 2'b00, mask_q[leaf], code_q[leaf]};
            if (out_cnt_q == OCNT_W'(2 * MAX_CHAR_COUNT - 1))
               state_d = DONE;
            else
               out_cnt_d = out_cnt_q + 1'b1;
         end

         DONE: ;

         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= LOAD;
         load_cnt_q <= '0;
         nodes_q    <= '0;
         chars_q    <= '0;
         new_idx_q  <= IDX_W'(MAX_CHAR_COUNT);
         code_q     <= '0;
         mask_q     <= '0;
         out_cnt_q  <= '0;
         io_out_q   <= '0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         nodes_q    <= nodes_d;
         chars_q    <= chars_d;
         new_idx_q  <= new_idx_d;
         code_q     <= code_d;
         mask_q     <= mask_d;
         out_cnt_q  <= out_cnt_d;
         io_out_q   <= io_out_d;
      end
   end

   assign io_out = io_out_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: directed runs plus randomized
// runs checked against a set-merging Huffman reference model.
module tb_huffman_encoder;

   logic        clk;
   logic        reset;
   logic [11:0] io_in;
   logic [11:0] io_out;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_ch  [3];
   logic [2:0]  m_fr  [3];
   logic [11:0] exp_w [6];

   huffman_encoder dut (
      .clk    (clk),
      .reset  (reset),
      .io_in  (io_in),
      .io_out (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: each live tree item is a set of leaves. Merging X,Y pushes a
   // new most-significant bit (0 for X's leaves, 1 for Y's) onto every member.
   task automatic build_model();
      int f[5];
      bit act[5];
      bit lf[5];
      int mem[5];
      int cval[3];
      int clen[3];
      int x, y;
      for (int i = 0; i < 5; i++) begin
         f[i] = 0; act[i] = 0; lf[i] = 0; mem[i] = 0;
      end
      for (int i = 0; i < 3; i++) begin
         f[i] = m_fr[i]; act[i] = 1; lf[i] = 1; mem[i] = 1 << i;
         cval[i] = 0; clen[i] = 0;
      end
      for (int n = 3; n < 5; n++) begin
         x = -1; y = -1;
         for (int i = 0; i < 5; i++) begin
            if (act[i]) begin
               if (x < 0 || f[i] < f[x] || (f[i] == f[x] && !lf[i] && lf[x]))
                  begin y = x; x = i; end
               else if (y < 0 || f[i] < f[y] || (f[i] == f[y] && !lf[i] && lf[y]))
                  y = i;
            end
         end
         for (int l = 0; l < 3; l++) begin
            if (mem[y][l]) cval[l] = cval[l] | (1 << clen[l]);
            if (mem[x][l] || mem[y][l]) clen[l]++;
         end
         f[n] = f[x] + f[y]; act[n] = 1; lf[n] = 0; mem[n] = mem[x] | mem[y];
         act[x] = 0; act[y] = 0;
      end
      for (int l = 0; l < 3; l++) begin
         logic [2:0] mk, cv;
         mk = 3'((1 << clen[l]) - 1);
         cv = 3'(cval[l]);
         exp_w[2*l]   = {3'b000, 1'b1, 3'b011, m_ch[l][4:0]};
         exp_w[2*l+1] = {3'b000, 1'b1, 2'b00, mk, cv};
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      io_in = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Loads m_ch/m_fr; optional random idle gaps; optional hold of the last
   // load word (valid bit still high) through the rest of the run.
   task automatic load_all(input bit gaps, input bit hold);
      for (int k = 0; k < 3; k++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(1, 3);
            for (int j = 0; j < g; j++) begin
               @(negedge clk);
               io_in = {1'b0, 11'($urandom)};
            end
         end
         @(negedge clk);
         io_in = {1'b1, m_fr[k], m_ch[k]};
      end
      @(negedge clk);
      if (!hold) io_in = {1'b0, 11'($urandom)};
   endtask

   // Called at the first negedge after the third load edge.
   task automatic wait_first(input string tag, output bit ok);
      int n;
      n = 1;
      ok = 1'b0;
      while (!io_out[8] && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = io_out[8];
      chk({tag, "_latency"}, n - 1, 4);
   endtask

   task automatic check_run(input string tag, input bit gaps, input bit hold);
      bit ok;
      load_all(gaps, hold);
      wait_first(tag, ok);
      if (!ok) return;
      for (int w = 0; w < 6; w++) begin
         if (w > 0) @(negedge clk);
         chk($sformatf("%s_word%0d", tag, w), io_out, exp_w[w]);
      end
      for (int d = 0; d < 3; d++) begin
         @(negedge clk);
         chk($sformatf("%s_done%0d", tag, d), io_out, 12'h000);
      end
   endtask

   task automatic set_syms(input logic [7:0] c0, input logic [2:0] f0,
                           input logic [7:0] c1, input logic [2:0] f1,
                           input logic [7:0] c2, input logic [2:0] f2);
      m_ch[0] = c0; m_fr[0] = f0;
      m_ch[1] = c1; m_fr[1] = f1;
      m_ch[2] = c2; m_fr[2] = f2;
   endtask

   initial begin
      bit ok;
      reset = 1'b0;
      io_in = '0;
      repeat (2) @(negedge clk);
      chk("reset_io_out", io_out, 12'h000);
      reset = 1'b1;

      // a=1, n=00, m=01
      set_syms("a", 3'd4, "n", 3'd2, "m", 3'd2);
      exp_w[0] = 12'h161; exp_w[1] = 12'h109;
      exp_w[2] = 12'h16E; exp_w[3] = 12'h118;
      exp_w[4] = 12'h16D; exp_w[5] = 12'h119;
      check_run("anm", 1'b0, 1'b0);

      do_reset();
      check_run("anm_hold", 1'b0, 1'b1);

      do_reset();
      check_run("anm_gaps", 1'b1, 1'b0);

      // c=1, a=00, b=01
      do_reset();
      set_syms("a", 3'd1, "b", 3'd2, "c", 3'd5);
      exp_w[0] = 12'h161; exp_w[1] = 12'h118;
      exp_w[2] = 12'h162; exp_w[3] = 12'h119;
      exp_w[4] = 12'h163; exp_w[5] = 12'h109;
      check_run("abc", 1'b0, 1'b0);

      // abort during OUTPUT after two words
      do_reset();
      load_all(1'b0, 1'b0);
      wait_first("abort", ok);
      @(negedge clk);
      chk("abort_word1", io_out, exp_w[1]);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_io_out", io_out, 12'h000);
      reset = 1'b1;

      // all-zero frequencies, tie rules only
      set_syms("x", 3'd0, "y", 3'd0, "z", 3'd0);
      build_model();
      check_run("xyz_zero", 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("xyz_done_hold", io_out, 12'h000);

      // randomized runs against the reference model
      for (int r = 0; r < 12; r++) begin
         do_reset();
         for (int k = 0; k < 3; k++) begin
            m_ch[k] = 8'($urandom);
            m_fr[k] = (r < 4) ? 3'($urandom_range(1, 2)) : 3'($urandom);
         end
         build_model();
         check_run($sformatf("rand%0d", r), 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
